ff256_ct_seq_demux_8_64: RTL and testbench

//  Byte-to-word deserializer: gathers N_BYTES serial bytes into one wide word. Inverse of the

---
 rtl/ff256_ct_seq_demux_8_64.sv | 89 ++++++++
 tb/tb_ff256_ct_seq_demux_8_64.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ff256_ct_seq_demux_8_64.sv
// rtl/ff256_ct_seq_demux_8_64.sv - byte-to-word deserializer with valid/ready on both sides
// Gathers N_BYTES serial bytes into one word, byte 0 in the LSBs.
module ff256_ct_seq_demux_8_64 #(
  parameter int BYTE_W  = 8,
  parameter int N_BYTES = 8,
  parameter int IDX_W   = $clog2(N_BYTES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [BYTE_W-1:0]         x_in,
  input  logic                      x_in_valid,
  output logic                      x_in_ready,
  output logic [BYTE_W*N_BYTES-1:0] x_out,
  output logic                      x_out_valid,
  input  logic                      x_out_ready,
  output logic [IDX_W-1:0]          byte_idx
);

  typedef enum logic {ST_FILL, ST_FULL} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [IDX_W-1:0]                r_byte_idx;
  logic [BYTE_W*(N_BYTES-1)-1:0]   r_shadow;
  logic [BYTE_W*N_BYTES-1:0]       r_x_out;
  logic                            w_in_ready;
  logic                            w_byte_acc;
  logic                            w_word_acc;

  // In FULL the next word's byte 0 may enter only while the current word drains.
  assign w_in_ready = ~clear & ((r_state == ST_FILL) | x_out_ready);
  assign w_byte_acc = x_in_valid & w_in_ready;
  assign w_word_acc = (r_state == ST_FULL) & x_out_ready & ~clear;

  assign x_in_ready  = w_in_ready;
  assign x_out_valid = (r_state == ST_FULL);
  assign x_out       = r_x_out;
  assign byte_idx    = r_byte_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL: if (w_byte_acc && (r_byte_idx == LAST_IDX)) w_state_nxt = ST_FULL;
        ST_FULL: if (w_word_acc) w_state_nxt = ST_FILL;
        default: w_state_nxt = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_idx <= '0;
      r_shadow   <= '0;
      r_x_out    <= '0;
    end else if (clear) begin
      r_byte_idx <= '0;
      r_shadow   <= '0;
    end else if (w_byte_acc) begin
      if (r_state == ST_FULL) begin
        r_shadow[BYTE_W-1:0] <= x_in;
        r_byte_idx           <= IDX_W'(1);
      end else if (r_byte_idx == LAST_IDX) begin
        // Last byte goes straight to the output word, bypassing the shadow.
        r_x_out    <= {x_in, r_shadow};
        r_byte_idx <= '0;
      end else begin
        for (int k = 0; k < N_BYTES - 1; k++) begin
          if (r_byte_idx == IDX_W'(k)) r_shadow[k*BYTE_W +: BYTE_W] <= x_in;
        end
        r_byte_idx <= r_byte_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ff256_ct_seq_demux_8_64.sv
// tb/tb_ff256_ct_seq_demux_8_64.sv - self-checking bench for the byte-to-word deserializer
module tb_ff256_ct_seq_demux_8_64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [7:0]  x_in;
  logic        x_in_valid;
  logic        x_in_ready;
  logic [63:0] x_out;
  logic        x_out_valid;
  logic        x_out_ready;
  logic [2:0]  byte_idx;

  int n_err = 0;
  int n_chk = 0;

  ff256_ct_seq_demux_8_64 dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .x_in(x_in), .x_in_valid(x_in_valid), .x_in_ready(x_in_ready),
    .x_out(x_out), .x_out_valid(x_out_valid), .x_out_ready(x_out_ready),
    .byte_idx(byte_idx)
  );

  always #5 clk = ~clk;

  // Reference model: a list of collected bytes plus one pending-word slot.
  int          m_cnt;
  logic [7:0]  m_buf [8];
  logic        m_full;
  logic [63:0] m_word;
  logic        m_rdy;
  logic        m_acc;
  assign m_rdy = !clear && (!m_full || x_out_ready);
  assign m_acc = x_in_valid && m_rdy;

  function automatic logic [63:0] pack_last(input logic [7:0] last);
    logic [63:0] w;
    for (int k = 0; k < 7; k++) w[8*k +: 8] = m_buf[k];
    w[63:56] = last;
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_full <= 1'b0;
      m_word <= '0;
    end else if (clear) begin
      m_cnt  <= 0;
      m_full <= 1'b0;
    end else begin
      if (m_full && x_out_ready) m_full <= 1'b0;
      if (m_acc) begin
        m_buf[m_cnt] <= x_in;
        if (m_cnt == 7) begin
          m_word <= pack_last(x_in);
          m_full <= 1'b1;
          m_cnt  <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; x_in = '0; x_in_valid = 1'b0; x_out_ready = 1'b1;
    #3;
    n_chk++; if (x_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", x_out_valid); end
    n_chk++; if (byte_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx got=%0d want=0", byte_idx); end
    n_chk++; if (x_out !== 64'h0) begin n_err++; $display("FAIL reset_xout got=%h want=0", x_out); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (x_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", x_in_ready); end
  endtask

  task automatic test_single_word();
    x_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 x_in = 8'(i + 1); x_in_valid = 1'b1;
      @(negedge clk);
      n_chk++; if (byte_idx !== 3'(i)) begin n_err++; $display("FAIL single_idx got=%0d want=%0d", byte_idx, i); end
    end
    @(posedge clk); #1 x_in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (x_out_valid !== 1'b1 || x_out !== 64'h0807060504030201) begin
      n_err++; $display("FAIL single_word got=%b/%h want=1/0807060504030201", x_out_valid, x_out);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (x_out_valid !== 1'b0) begin n_err++; $display("FAIL single_drop got=%b want=0", x_out_valid); end
  endtask

  task automatic test_backpressure();
    x_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 x_in = 8'(8'h31 + i); x_in_valid = 1'b1;
      @(negedge clk);
      n_chk++; if (x_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_fill_ready got=%b want=1", x_in_ready); end
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1 x_in = 8'h99;
      @(negedge clk);
      n_chk++; if (x_in_ready !== 1'b0 || x_out_valid !== 1'b1 || byte_idx !== 3'd0 || x_out !== 64'h3837363534333231) begin
        n_err++; $display("FAIL bp_hold got rdy=%b vld=%b idx=%0d xout=%h want rdy=0 vld=1 idx=0 xout=3837363534333231",
                          x_in_ready, x_out_valid, byte_idx, x_out);
      end
    end
    @(posedge clk); #1 x_out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (x_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_drain_ready got=%b want=1", x_in_ready); end
    @(posedge clk); #1 x_in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (x_out_valid !== 1'b0 || byte_idx !== 3'd1) begin
      n_err++; $display("FAIL bp_after got vld=%b idx=%0d want vld=0 idx=1", x_out_valid, byte_idx);
    end
    @(posedge clk); #1 clear = 1'b1;
    @(negedge clk);
    n_chk++; if (x_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_clear_ready got=%b want=0", x_in_ready); end
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    n_chk++; if (byte_idx !== 3'd0) begin n_err++; $display("FAIL bp_clear_idx got=%0d want=0", byte_idx); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w0, w1;
    for (int k = 0; k < 8; k++) begin
      w0[8*k +: 8] = 8'(8'h10 + k);
      w1[8*k +: 8] = 8'(8'h18 + k);
    end
    x_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1 x_in = 8'(8'h10 + i); x_in_valid = 1'b1;
      @(negedge clk);
      n_chk++; if (x_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready i=%0d got=%b want=1", i, x_in_ready); end
      n_chk++; if (x_out_valid !== (i == 8)) begin n_err++; $display("FAIL b2b_valid i=%0d got=%b want=%b", i, x_out_valid, i == 8); end
      if (i == 8) begin
        n_chk++; if (x_out !== w0) begin n_err++; $display("FAIL b2b_word0 got=%h want=%h", x_out, w0); end
      end
    end
    @(posedge clk); #1 x_in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (x_out_valid !== 1'b1 || x_out !== w1) begin
      n_err++; $display("FAIL b2b_word1 got=%b/%h want=1/%h", x_out_valid, x_out, w1);
    end
  endtask

  task automatic test_clear();
    x_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 x_in = 8'(8'hC0 + i); x_in_valid = 1'b1;
    end
    @(posedge clk); #1 clear = 1'b1; x_in = 8'hEE;
    @(negedge clk);
    n_chk++; if (x_in_ready !== 1'b0) begin n_err++; $display("FAIL clr_ready got=%b want=0", x_in_ready); end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 clear = 1'b0; x_in = 8'(8'hA0 + i);
    end
    @(posedge clk); #1 x_in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (x_out_valid !== 1'b1 || x_out !== 64'hA7A6A5A4A3A2A1A0) begin
      n_err++; $display("FAIL clr_word got=%b/%h want=1/a7a6a5a4a3a2a1a0", x_out_valid, x_out);
    end
  endtask

  task automatic test_async_reset();
    x_out_ready = 1'b0;
    @(posedge clk); #1;
    x_out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 x_in = 8'(8'h50 + i); x_in_valid = 1'b1;
    end
    @(posedge clk); #1 x_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (byte_idx !== 3'd0 || x_out !== 64'h0 || x_out_valid !== 1'b0) begin
      n_err++; $display("FAIL async_rst got idx=%0d xout=%h vld=%b want 0/0/0", byte_idx, x_out, x_out_valid);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0]  sb[$];
    logic [63:0] exp_w;
    int n_acc = 0;
    int n_words = 0;
    int cyc = 0;
    while ((n_acc < 1000 || n_words < 125) && cyc < 20000) begin
      @(posedge clk); #1;
      x_in        = 8'($urandom);
      x_in_valid  = (n_acc < 1000) && ($urandom_range(0, 3) != 0);
      x_out_ready = (n_acc >= 1000) || ($urandom_range(0, 2) != 0);
      @(negedge clk);
      cyc++;
      n_chk++; if (x_in_ready !== m_rdy || x_out_valid !== m_full || byte_idx !== 3'(m_cnt)) begin
        n_err++; $display("FAIL rnd_ctrl cyc=%0d got rdy=%b vld=%b idx=%0d want rdy=%b vld=%b idx=%0d",
                          cyc, x_in_ready, x_out_valid, byte_idx, m_rdy, m_full, m_cnt);
      end
      if (m_full) begin
        n_chk++; if (x_out !== m_word) begin n_err++; $display("FAIL rnd_hold got=%h want=%h", x_out, m_word); end
      end
      if (x_out_valid && x_out_ready) begin
        for (int k = 0; k < 8; k++) exp_w[8*k +: 8] = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_words++;
        n_chk++; if (x_out !== exp_w) begin n_err++; $display("FAIL rnd_word n=%0d got=%h want=%h", n_words, x_out, exp_w); end
      end
      if (m_acc) begin
        sb.push_back(x_in);
        n_acc++;
      end
    end
    x_in_valid = 1'b0;
    n_chk++; if (n_words != 125 || sb.size() != 0) begin
      n_err++; $display("FAIL rnd_count got words=%0d left=%0d want words=125 left=0", n_words, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
